// File: rtl/reorder_buffer_pkg.sv
// ============================================================================
//  Module      : reorder_buffer_pkg
//  Description : Shared definitions for the reorder buffer slice: default
//                sizing, position/data types, zero constants and a pc helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ROB_DEFS_SV
`define ROB_DEFS_SV
`define ROB_POS_TYPE logic [3:0]
`define REG_POS_TYPE logic [4:0]
`define DATA_TYPE    logic [31:0]
`define ZERO_REG     5'd0
`define ZERO_ROB     4'd0
`define TRUE         1'b1
`define FALSE        1'b0
`endif

package reorder_buffer_pkg;

    localparam int DEF_ROB_SIZE = 16;
    localparam int DEF_ROB_W    = 4;

    typedef logic [DEF_ROB_W-1:0] rob_pos_t;
    typedef logic [4:0]           reg_pos_t;
    typedef logic [31:0]          data_t;

    localparam reg_pos_t ZERO_REG = 5'd0;
    localparam rob_pos_t ZERO_ROB = 4'd0;

    // Fall-through address of an instruction, used as the not-taken redirect.
    function automatic data_t next_pc(input data_t pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_query_port.sv
// ============================================================================
//  Module      : rob_query_port
//  Description : Operand tag lookup into the reorder buffer. Returns the
//                stored ready bit and value of the addressed entry.
//                With ROB_BYPASS_EN defined, a same-cycle CDB broadcast on the
//                queried tag (ALU first, then LSB) is forwarded as ready.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_query_port
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = DEF_ROB_SIZE,
    parameter int ROB_W    = $clog2(ROB_SIZE)
) (
    input  logic [ROB_W-1:0]    in_tag,
    input  logic [ROB_SIZE-1:0] in_ready_vec,
    input  data_t               in_value_arr [ROB_SIZE],
    input  logic                in_alu_valid,
    input  logic [ROB_W-1:0]    in_alu_rob,
    input  logic [31:0]         in_alu_value,
    input  logic                in_lsb_valid,
    input  logic [ROB_W-1:0]    in_lsb_rob,
    input  logic [31:0]         in_lsb_value,
    output logic                out_ready,
    output logic [31:0]         out_value
);

    // Stored-state lookup, optionally overridden by a matching CDB broadcast.
    always_comb begin
        out_ready = in_ready_vec[in_tag];
        out_value = in_value_arr[in_tag];
`ifdef ROB_BYPASS_EN
        if (in_alu_valid && (in_alu_rob == in_tag)) begin
            out_ready = 1'b1;
            out_value = in_alu_value;
        end else if (in_lsb_valid && (in_lsb_rob == in_tag)) begin
            out_ready = 1'b1;
            out_value = in_lsb_value;
        end
`endif
    end

`ifndef ROB_BYPASS_EN
    // CDB inputs only matter when bypass is built in.
    logic unused_cdb;
    assign unused_cdb = ^{in_alu_valid, in_alu_rob, in_alu_value,
                          in_lsb_valid, in_lsb_rob, in_lsb_value};
`endif

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular in-order reorder buffer. Allocates one entry per
//                issue, captures ALU/LSB results from the CDB and retires at
//                most one ready head entry per cycle. A mispredicted branch at
//                the head flushes the buffer and raises out_xbp.
//                Optional macro ROB_BYPASS_EN: query ports forward same-cycle
//                CDB results.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = DEF_ROB_SIZE,
    parameter int ROB_W    = $clog2(ROB_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_issue_valid,
    input  logic [4:0]       in_issue_dest_reg,
    input  logic             in_issue_is_store,
    input  logic             in_issue_is_branch,
    input  logic             in_issue_pred_taken,
    input  logic [31:0]      in_issue_pc,
    output logic [ROB_W-1:0] out_issue_rob,
    output logic             out_full,
    input  logic             in_alu_valid,
    input  logic [ROB_W-1:0] in_alu_rob,
    input  logic [31:0]      in_alu_value,
    input  logic             in_alu_taken,
    input  logic [31:0]      in_alu_target,
    input  logic             in_lsb_valid,
    input  logic [ROB_W-1:0] in_lsb_rob,
    input  logic [31:0]      in_lsb_value,
    input  logic [ROB_W-1:0] in_query_rob1,
    input  logic [ROB_W-1:0] in_query_rob2,
    output logic             out_query_ready1,
    output logic             out_query_ready2,
    output logic [31:0]      out_query_value1,
    output logic [31:0]      out_query_value2,
    output logic [4:0]       out_commit_reg,
    output logic [ROB_W-1:0] out_commit_rob,
    output logic [31:0]      out_commit_value,
    output logic             out_store_commit,
    output logic             out_xbp,
    output logic [31:0]      out_xbp_pc
);

    localparam logic [ROB_W:0]   FULL_COUNT = (ROB_W+1)'(ROB_SIZE);
    localparam logic [ROB_W:0]   COUNT_ONE  = (ROB_W+1)'(1);
    localparam logic [ROB_W-1:0] POS_ONE    = (ROB_W)'(1);

    // Pointers and occupancy
    logic [ROB_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]      count_q, count_d;

    // Entry fields as parallel arrays indexed by tag
    logic [ROB_SIZE-1:0] valid_q, valid_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    logic [ROB_SIZE-1:0] is_store_q, is_store_d;
    logic [ROB_SIZE-1:0] is_branch_q, is_branch_d;
    logic [ROB_SIZE-1:0] pred_q, pred_d;
    logic [ROB_SIZE-1:0] taken_q, taken_d;
    reg_pos_t            dest_q   [ROB_SIZE];
    reg_pos_t            dest_d   [ROB_SIZE];
    data_t               pc_q     [ROB_SIZE];
    data_t               pc_d     [ROB_SIZE];
    data_t               target_q [ROB_SIZE];
    data_t               target_d [ROB_SIZE];
    data_t               value_q  [ROB_SIZE];
    data_t               value_d  [ROB_SIZE];

    // Registered retire outputs
    reg_pos_t            commit_reg_q, commit_reg_d;
    logic [ROB_W-1:0]    commit_rob_q, commit_rob_d;
    data_t               commit_value_q, commit_value_d;
    logic                store_commit_q, store_commit_d;
    logic                xbp_q, xbp_d;
    data_t               xbp_pc_q, xbp_pc_d;

    logic                w_full;
    logic                w_issue_fire;
    logic                w_head_fire;
    logic                w_mispredict;

    assign w_full        = (count_q == FULL_COUNT);
    assign w_issue_fire  = in_issue_valid & ~w_full;
    assign w_head_fire   = valid_q[head_q] & ready_q[head_q];
    assign w_mispredict  = w_head_fire & is_branch_q[head_q]
                         & (taken_q[head_q] != pred_q[head_q]);

    assign out_issue_rob    = tail_q;
    assign out_full         = w_full;
    assign out_commit_reg   = commit_reg_q;
    assign out_commit_rob   = commit_rob_q;
    assign out_commit_value = commit_value_q;
    assign out_store_commit = store_commit_q;
    assign out_xbp          = xbp_q;
    assign out_xbp_pc       = xbp_pc_q;

    // Next-state: retire/flush of the head, CDB capture, then allocation.
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        valid_d        = valid_q;
        ready_d        = ready_q;
        is_store_d     = is_store_q;
        is_branch_d    = is_branch_q;
        pred_d         = pred_q;
        taken_d        = taken_q;
        dest_d         = dest_q;
        pc_d           = pc_q;
        target_d       = target_q;
        value_d        = value_q;
        commit_reg_d   = ZERO_REG;
        commit_rob_d   = '0;
        commit_value_d = '0;
        store_commit_d = 1'b0;
        xbp_d          = 1'b0;
        xbp_pc_d       = '0;

        // The head instruction itself retires even when it redirects, so a
        // jalr still delivers its link register.
        if (w_head_fire) begin
            commit_reg_d   = dest_q[head_q];
            commit_rob_d   = head_q;
            commit_value_d = value_q[head_q];
            store_commit_d = is_store_q[head_q];
        end

        if (w_mispredict) begin
            xbp_d    = 1'b1;
            xbp_pc_d = taken_q[head_q] ? target_q[head_q] : next_pc(pc_q[head_q]);
            valid_d  = '0;
            ready_d  = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end else begin
            if (in_alu_valid && valid_q[in_alu_rob]) begin
                ready_d[in_alu_rob] = 1'b1;
                value_d[in_alu_rob] = in_alu_value;
                if (is_branch_q[in_alu_rob]) begin
                    taken_d[in_alu_rob]  = in_alu_taken;
                    target_d[in_alu_rob] = in_alu_target;
                end
            end
            if (in_lsb_valid && valid_q[in_lsb_rob]) begin
                ready_d[in_lsb_rob] = 1'b1;
                value_d[in_lsb_rob] = in_lsb_value;
            end

            if (w_head_fire) begin
                valid_d[head_q] = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + POS_ONE;
            end

            // Every entry waits for a CDB report before it may retire.
            if (w_issue_fire) begin
                valid_d[tail_q]     = 1'b1;
                ready_d[tail_q]     = 1'b0;
                dest_d[tail_q]      = in_issue_dest_reg;
                is_store_d[tail_q]  = in_issue_is_store;
                is_branch_d[tail_q] = in_issue_is_branch;
                pred_d[tail_q]      = in_issue_pred_taken;
                taken_d[tail_q]     = 1'b0;
                pc_d[tail_q]        = in_issue_pc;
                tail_d              = tail_q + POS_ONE;
            end

            case ({w_issue_fire, w_head_fire})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers: async clear, update only when the core is enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            ready_q        <= '0;
            is_store_q     <= '0;
            is_branch_q    <= '0;
            pred_q         <= '0;
            taken_q        <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                dest_q[i]   <= ZERO_REG;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
                value_q[i]  <= '0;
            end
            commit_reg_q   <= ZERO_REG;
            commit_rob_q   <= '0;
            commit_value_q <= '0;
            store_commit_q <= 1'b0;
            xbp_q          <= 1'b0;
            xbp_pc_q       <= '0;
        end else if (rdy) begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            is_store_q     <= is_store_d;
            is_branch_q    <= is_branch_d;
            pred_q         <= pred_d;
            taken_q        <= taken_d;
            dest_q         <= dest_d;
            pc_q           <= pc_d;
            target_q       <= target_d;
            value_q        <= value_d;
            commit_reg_q   <= commit_reg_d;
            commit_rob_q   <= commit_rob_d;
            commit_value_q <= commit_value_d;
            store_commit_q <= store_commit_d;
            xbp_q          <= xbp_d;
            xbp_pc_q       <= xbp_pc_d;
        end
    end

    rob_query_port #(
        .ROB_SIZE (ROB_SIZE),
        .ROB_W    (ROB_W)
    ) u_query1 (
        .in_tag       (in_query_rob1),
        .in_ready_vec (ready_q),
        .in_value_arr (value_q),
        .in_alu_valid (in_alu_valid),
        .in_alu_rob   (in_alu_rob),
        .in_alu_value (in_alu_value),
        .in_lsb_valid (in_lsb_valid),
        .in_lsb_rob   (in_lsb_rob),
        .in_lsb_value (in_lsb_value),
        .out_ready    (out_query_ready1),
        .out_value    (out_query_value1)
    );

    rob_query_port #(
        .ROB_SIZE (ROB_SIZE),
        .ROB_W    (ROB_W)
    ) u_query2 (
        .in_tag       (in_query_rob2),
        .in_ready_vec (ready_q),
        .in_value_arr (value_q),
        .in_alu_valid (in_alu_valid),
        .in_alu_rob   (in_alu_rob),
        .in_alu_value (in_alu_value),
        .in_lsb_valid (in_lsb_valid),
        .in_lsb_rob   (in_lsb_rob),
        .in_lsb_value (in_lsb_value),
        .out_ready    (out_query_ready2),
        .out_value    (out_query_value2)
    );

endmodule

`default_nettype wire
